// File: rtl/cs_threshold_trainer.sv
`default_nettype none
// ============================================================================
// cs_threshold_trainer : averages a quiet-channel magnitude window and derives
// the carrier-sense detection threshold (avg + avg>>MARGIN_SHIFT + OFFSET).
// Revision: 1.0
// ============================================================================
module cs_threshold_trainer #(
  parameter int          MAG_WIDTH      = 16,
  parameter int          LOG2_N         = 8,
  parameter int          SETTLE_SAMPLES = 4,
  parameter int          MARGIN_SHIFT   = 1,
  parameter logic [31:0] OFFSET         = 32'd0,
  parameter logic [31:0] INIT_THRESHOLD = 32'd100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MAG_WIDTH-1:0] mag_in,
  input  logic                 mag_valid,
  input  logic                 train_start,
  input  logic                 train_abort,
  output logic [31:0]          threshold_out,
  output logic                 threshold_changed,
  output logic                 threshold_valid,
  output logic                 busy,
  output logic [MAG_WIDTH-1:0] noise_avg
);

  localparam int c_ACC_W = MAG_WIDTH + LOG2_N;
  localparam int c_CNT_W = (LOG2_N + 1 > 8) ? LOG2_N + 1 : 8;

  localparam logic [c_CNT_W-1:0] c_ACC_LAST    = c_CNT_W'((1 << LOG2_N) - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_SAMPLES - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SETTLE = 3'd1;
  localparam logic [2:0] c_ACCUM  = 3'd2;
  localparam logic [2:0] c_CALC   = 3'd3;
  localparam logic [2:0] c_UPDATE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [c_ACC_W-1:0]   acc_q, acc_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          threshold_q;
  logic                 changed_q;
  logic                 valid_q;
  logic                 busy_q;
  logic [MAG_WIDTH-1:0] avg_q;

  logic [32:0]          w_sum;
  logic                 w_calc_fire;
  logic                 w_update_fire;

  // 33-bit sum so that the carry out flags saturation
  assign w_sum = 33'(avg_q) + 33'(avg_q >> MARGIN_SHIFT) + 33'(OFFSET);

  assign w_calc_fire   = (state_q == c_CALC)   && !train_abort;
  assign w_update_fire = (state_q == c_UPDATE) && !train_abort;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (train_abort) begin
      state_d = c_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (train_start) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = (SETTLE_SAMPLES == 0) ? c_ACCUM : c_SETTLE;
          end
        end
        c_SETTLE: begin
          if (mag_valid) begin
            if (cnt_q == c_SETTLE_LAST) begin
              cnt_d   = '0;
              state_d = c_ACCUM;
            end else begin
              cnt_d = cnt_q + c_CNT_W'(1);
            end
          end
        end
        c_ACCUM: begin
          if (mag_valid) begin
            acc_d = acc_q + c_ACC_W'(mag_in);
            if (cnt_q == c_ACC_LAST) begin
              cnt_d   = '0;
              state_d = c_CALC;
            end else begin
              cnt_d = cnt_q + c_CNT_W'(1);
            end
          end
        end
        c_CALC:   state_d = c_UPDATE;
        c_UPDATE: state_d = c_IDLE;
        default:  state_d = c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      threshold_q <= INIT_THRESHOLD;
      changed_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      avg_q       <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != c_IDLE);
      changed_q <= w_update_fire;
      if (w_calc_fire) begin
        avg_q <= MAG_WIDTH'(acc_q >> LOG2_N);
      end
      if (w_update_fire) begin
        threshold_q <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
        valid_q     <= 1'b1;
      end
    end
  end

  assign threshold_out     = threshold_q;
  assign threshold_changed = changed_q;
  assign threshold_valid   = valid_q;
  assign busy              = busy_q;
  assign noise_avg         = avg_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_threshold_trainer.sv
`default_nettype none
// Testbench for cs_threshold_trainer: randomized windows against an arithmetic model.
module tb_cs_threshold_trainer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mag_in;
  logic        mag_valid, train_start, train_abort;
  logic [31:0] threshold_out;
  logic        threshold_changed, threshold_valid, busy;
  logic [15:0] noise_avg;

  logic [15:0] s_mag_in;
  logic        s_mag_valid, s_train_start, s_train_abort;
  logic [31:0] s_threshold_out;
  logic        s_threshold_changed, s_threshold_valid, s_busy;
  logic [15:0] s_noise_avg;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  logic [15:0] samp [16];

  always #5 clk = ~clk;

  cs_threshold_trainer #(
    .MAG_WIDTH(16), .LOG2_N(4), .SETTLE_SAMPLES(2), .MARGIN_SHIFT(1),
    .OFFSET(32'd10), .INIT_THRESHOLD(32'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_valid(mag_valid),
    .train_start(train_start), .train_abort(train_abort),
    .threshold_out(threshold_out), .threshold_changed(threshold_changed),
    .threshold_valid(threshold_valid), .busy(busy), .noise_avg(noise_avg)
  );

  cs_threshold_trainer #(
    .MAG_WIDTH(16), .LOG2_N(4), .SETTLE_SAMPLES(2), .MARGIN_SHIFT(1),
    .OFFSET(32'hFFFF_FFF0), .INIT_THRESHOLD(32'd100)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .mag_in(s_mag_in), .mag_valid(s_mag_valid),
    .train_start(s_train_start), .train_abort(s_train_abort),
    .threshold_out(s_threshold_out), .threshold_changed(s_threshold_changed),
    .threshold_valid(s_threshold_valid), .busy(s_busy), .noise_avg(s_noise_avg)
  );

  always @(negedge clk) if (threshold_changed === 1'b1) n_strobe++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned ref_avg();
    longint unsigned sum = 0;
    for (int i = 0; i < 16; i++) sum += samp[i];
    return sum / 16;
  endfunction

  function automatic logic [31:0] ref_thr(input longint unsigned avg, input longint unsigned off);
    longint unsigned t;
    t = avg + avg / 2 + off;
    if (t > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return t[31:0];
  endfunction

  // One run: start pulse, 2 discarded samples, 16 window samples from samp[].
  // abort_mode: 0 none, 1 abort with last sample, 2 abort during CALC.
  // Observations are indexed by cycle k+m where edge k took the last sample.
  task automatic drive_run(input int gap, input int abort_mode, input int start_mid,
                           output int strobe_at, output int strobes,
                           output logic busy_k1, output logic busy_k2,
                           output logic busy_k3, output logic [15:0] avg_k2);
    int s0;
    s0 = n_strobe;
    strobe_at = -1;
    busy_k2 = 1'bx;
    busy_k3 = 1'bx;
    avg_k2 = 'x;
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      for (int g = 0; g < gap; g++) begin
        mag_valid = 1'b0;
        mag_in = 16'($urandom);
        tick();
      end
      mag_valid = 1'b1;
      mag_in = (i < 2) ? 16'($urandom) : samp[i-2];
      if (start_mid != 0 && i == 10) train_start = 1'b1;
      if (abort_mode == 1 && i == 17) train_abort = 1'b1;
      tick();
      train_start = 1'b0;
      train_abort = 1'b0;
    end
    mag_valid = 1'b0;
    busy_k1 = busy;
    for (int c = 1; c <= 7; c++) begin
      if (c == 1 && abort_mode == 2) train_abort = 1'b1;
      tick();
      train_abort = 1'b0;
      if (c == 1) begin busy_k2 = busy; avg_k2 = noise_avg; end
      if (c == 2) busy_k3 = busy;
      if (threshold_changed === 1'b1 && strobe_at < 0) strobe_at = c + 1;
    end
    strobes = n_strobe - s0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (threshold_out !== 32'd100) begin n_err++; $display("FAIL reset_thr: got %0d expected 100", threshold_out); end
    n_cmp++; if (threshold_changed !== 1'b0) begin n_err++; $display("FAIL reset_chg: got %b expected 0", threshold_changed); end
    n_cmp++; if (threshold_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", threshold_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (noise_avg !== 16'd0) begin n_err++; $display("FAIL reset_avg: got %0d expected 0", noise_avg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    for (int i = 0; i < 16; i++) samp[i] = 16'd200;
    drive_run(0, 1, 0, sa, ns, b1, b2, b3, av);
    n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL abort_last_busy: got %b expected 0", b1); end
    n_cmp++; if (ns !== 0) begin n_err++; $display("FAIL abort_last_strobes: got %0d expected 0", ns); end
    n_cmp++; if (threshold_out !== 32'd100) begin n_err++; $display("FAIL abort_last_thr: got %0d expected 100", threshold_out); end
    n_cmp++; if (threshold_valid !== 1'b0) begin n_err++; $display("FAIL abort_last_valid: got %b expected 0", threshold_valid); end
    drive_run(0, 2, 0, sa, ns, b1, b2, b3, av);
    n_cmp++; if (b2 !== 1'b0) begin n_err++; $display("FAIL abort_calc_busy: got %b expected 0", b2); end
    n_cmp++; if (ns !== 0) begin n_err++; $display("FAIL abort_calc_strobes: got %0d expected 0", ns); end
    n_cmp++; if (threshold_out !== 32'd100) begin n_err++; $display("FAIL abort_calc_thr: got %0d expected 100", threshold_out); end
    n_cmp++; if (av !== 16'd0) begin n_err++; $display("FAIL abort_calc_avg: got %0d expected 0", av); end
  endtask

  task automatic test_basic();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    logic [31:0] exp_thr;
    for (int i = 0; i < 16; i++) samp[i] = 16'd200;
    exp_thr = ref_thr(ref_avg(), 10);
    drive_run(0, 0, 0, sa, ns, b1, b2, b3, av);
    n_cmp++; if (av !== 16'(ref_avg())) begin n_err++; $display("FAIL basic_avg: got %0d expected %0d", av, ref_avg()); end
    n_cmp++; if (threshold_out !== exp_thr || exp_thr !== 32'd310) begin n_err++; $display("FAIL basic_thr: got %0d expected 310", threshold_out); end
    n_cmp++; if (sa !== 3) begin n_err++; $display("FAIL basic_strobe_time: got %0d expected 3", sa); end
    n_cmp++; if (ns !== 1) begin n_err++; $display("FAIL basic_strobes: got %0d expected 1", ns); end
    n_cmp++; if (b1 !== 1'b1 || b3 !== 1'b0) begin n_err++; $display("FAIL basic_busy: got k1=%b k3=%b expected 1/0", b1, b3); end
    n_cmp++; if (threshold_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", threshold_valid); end
    n_cmp++; if (threshold_changed !== 1'b0) begin n_err++; $display("FAIL basic_chg_clear: got %b expected 0", threshold_changed); end
  endtask

  task automatic test_truncate();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? 16'd7 : 16'd8;
    drive_run(0, 0, 0, sa, ns, b1, b2, b3, av);
    n_cmp++; if (av !== 16'(ref_avg())) begin n_err++; $display("FAIL trunc_avg: got %0d expected %0d", av, ref_avg()); end
    n_cmp++; if (threshold_out !== ref_thr(ref_avg(), 10)) begin n_err++; $display("FAIL trunc_thr: got %0d expected %0d", threshold_out, ref_thr(ref_avg(), 10)); end
  endtask

  task automatic test_gaps();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    for (int i = 0; i < 16; i++) samp[i] = 16'($urandom_range(0, 4000));
    drive_run(2, 0, 1, sa, ns, b1, b2, b3, av);
    n_cmp++; if (av !== 16'(ref_avg())) begin n_err++; $display("FAIL gaps_avg: got %0d expected %0d", av, ref_avg()); end
    n_cmp++; if (threshold_out !== ref_thr(ref_avg(), 10)) begin n_err++; $display("FAIL gaps_thr: got %0d expected %0d", threshold_out, ref_thr(ref_avg(), 10)); end
    n_cmp++; if (ns !== 1 || sa !== 3) begin n_err++; $display("FAIL gaps_strobe: got n=%0d at=%0d expected 1 at 3", ns, sa); end
  endtask

  task automatic test_random();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) samp[i] = 16'($urandom);
      drive_run(int'($urandom_range(0, 2)), 0, 0, sa, ns, b1, b2, b3, av);
      n_cmp++; if (av !== 16'(ref_avg())) begin n_err++; $display("FAIL rand%0d_avg: got %0d expected %0d", r, av, ref_avg()); end
      n_cmp++; if (threshold_out !== ref_thr(ref_avg(), 10)) begin n_err++; $display("FAIL rand%0d_thr: got %0d expected %0d", r, threshold_out, ref_thr(ref_avg(), 10)); end
      n_cmp++; if (ns !== 1 || sa !== 3) begin n_err++; $display("FAIL rand%0d_strobe: got n=%0d at=%0d expected 1 at 3", r, ns, sa); end
    end
  endtask

  task automatic test_saturation();
    int waited;
    for (int i = 0; i < 16; i++) samp[i] = 16'hFFFF;
    s_train_start = 1'b1;
    tick();
    s_train_start = 1'b0;
    s_mag_valid = 1'b1;
    s_mag_in = 16'hFFFF;
    for (int i = 0; i < 18; i++) tick();
    s_mag_valid = 1'b0;
    waited = 0;
    while (s_busy === 1'b1 && waited < 10) begin tick(); waited++; end
    n_cmp++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL sat_timeout: busy=%b after %0d cycles expected 0", s_busy, waited); end
    n_cmp++; if (s_threshold_out !== ref_thr(ref_avg(), 64'h0000_0000_FFFF_FFF0)) begin n_err++; $display("FAIL sat_thr: got %h expected %h", s_threshold_out, ref_thr(ref_avg(), 64'h0000_0000_FFFF_FFF0)); end
    n_cmp++; if (s_noise_avg !== 16'hFFFF || s_threshold_valid !== 1'b1) begin n_err++; $display("FAIL sat_avg_valid: got avg=%h valid=%b expected ffff/1", s_noise_avg, s_threshold_valid); end
  endtask

  task automatic test_reset_midrun();
    int sa, ns; logic b1, b2, b3; logic [15:0] av;
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    mag_valid = 1'b1;
    mag_in = 16'd500;
    for (int i = 0; i < 7; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (threshold_out !== 32'd100) begin n_err++; $display("FAIL rstmid_thr: got %0d expected 100", threshold_out); end
    n_cmp++; if (threshold_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_valid_busy: got %b/%b expected 0/0", threshold_valid, busy); end
    n_cmp++; if (noise_avg !== 16'd0 || threshold_changed !== 1'b0) begin n_err++; $display("FAIL rstmid_avg_chg: got %0d/%b expected 0/0", noise_avg, threshold_changed); end
    mag_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) samp[i] = 16'($urandom_range(100, 9000));
    drive_run(1, 0, 0, sa, ns, b1, b2, b3, av);
    n_cmp++; if (threshold_out !== ref_thr(ref_avg(), 10)) begin n_err++; $display("FAIL rstmid_rerun_thr: got %0d expected %0d", threshold_out, ref_thr(ref_avg(), 10)); end
    n_cmp++; if (ns !== 1 || threshold_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_rerun_strobe: got n=%0d valid=%b expected 1/1", ns, threshold_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    mag_in = '0; mag_valid = 1'b0; train_start = 1'b0; train_abort = 1'b0;
    s_mag_in = '0; s_mag_valid = 1'b0; s_train_start = 1'b0; s_train_abort = 1'b0;
    test_reset();
    test_abort();
    test_basic();
    test_truncate();
    test_gaps();
    test_random();
    test_saturation();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
